// File: rtl/pu_slave_spi_pbuf.sv
// SPI slave processing unit with double-buffered NITTA banks: write/send and receive/read
// pairs swap at computational-cycle boundaries, deferred while an SPI frame is in progress.
module pu_slave_spi_pbuf #(
  parameter int DATA_WIDTH = 32,
  parameter int ATTR_WIDTH = 4,
  parameter int BUF_SIZE   = 10,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signal_cycle,
  input  logic                  signal_wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ATTR_WIDTH-1:0] attr_in,
  input  logic                  signal_oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ATTR_WIDTH-1:0] attr_out,
  input  logic                  mosi,
  input  logic                  sclk,
  input  logic                  cs,
  output logic                  miso
);
  localparam int AW = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int CW = $clog2(BUF_SIZE + 1);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BUF_FULL = CW'(BUF_SIZE);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] wmem [2][BUF_SIZE];
  logic [DATA_WIDTH-1:0] rmem [2][BUF_SIZE];

  logic [1:0] mosi_sy, sclk_sy, cs_sy;
  logic       sclk_q, cs_q;
  logic       ws_sel, rr_sel, swap_pend, wr_ovf, spi_ovf;
  logic       armed, frame_act, rx_push, rd_valid;
  logic [CW-1:0] write_cnt, send_cnt, recv_cnt, read_cnt, read_ptr, send_ptr;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_word, tx_shift, tx_next_word, rd_word;

  logic unused_attr;
  assign unused_attr = ^attr_in;

  logic mosi_s, sclk_s, cs_s;
  assign mosi_s = mosi_sy[1];
  assign sclk_s = sclk_sy[1];
  assign cs_s   = cs_sy[1];

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge, cs_fall, cs_rise;
  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign lead_edge   = (CPOL != 0) ? sclk_fall : sclk_rise;
  assign trail_edge  = (CPOL != 0) ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign cs_fall     = armed & cs_q & ~cs_s;
  assign cs_rise     = cs_s & ~cs_q;

  // Everything NITTA-side in the swap clock already sees the post-swap banks.
  logic          swap, ws_sel_n, rr_sel_n, ovf_e, wr_ok, rd_ok, push_ok, send_avail;
  logic [CW-1:0] wr_cnt_e, rcv_cnt_e, rd_cnt_e, rd_ptr_e;
  assign swap       = cs_s & (signal_cycle | swap_pend);
  assign ws_sel_n   = ws_sel ^ swap;
  assign rr_sel_n   = rr_sel ^ swap;
  assign wr_cnt_e   = swap ? '0 : write_cnt;
  assign rcv_cnt_e  = swap ? '0 : recv_cnt;
  assign rd_cnt_e   = swap ? recv_cnt : read_cnt;
  assign rd_ptr_e   = swap ? '0 : read_ptr;
  assign ovf_e      = swap ? 1'b0 : (wr_ovf | spi_ovf);
  assign wr_ok      = signal_wr & (wr_cnt_e < BUF_FULL);
  assign rd_ok      = signal_oe & (rd_ptr_e < rd_cnt_e);
  assign push_ok    = rx_push & (rcv_cnt_e < BUF_FULL);
  assign send_avail = send_ptr < send_cnt;

  assign data_out = rd_valid ? rd_word : '0;
  assign miso     = frame_act & tx_shift[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (wr_ok)
      wmem[ws_sel_n][wr_cnt_e[AW-1:0]] <= data_in;
    if (push_ok)
      rmem[rr_sel_n][rcv_cnt_e[AW-1:0]] <= rx_word;
    if (signal_oe)
      rd_word <= rmem[~rr_sel_n][rd_ptr_e[AW-1:0]];
    // Prefetch so a word is ready the moment the shifter asks for it.
    tx_next_word <= wmem[~ws_sel_n][send_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mosi_sy   <= '0;
      sclk_sy   <= '0;
      cs_sy     <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b0;
      ws_sel    <= 1'b0;
      rr_sel    <= 1'b0;
      swap_pend <= 1'b0;
      wr_ovf    <= 1'b0;
      spi_ovf   <= 1'b0;
      armed     <= 1'b0;
      frame_act <= 1'b0;
      rx_push   <= 1'b0;
      rd_valid  <= 1'b0;
      write_cnt <= '0;
      send_cnt  <= '0;
      recv_cnt  <= '0;
      read_cnt  <= '0;
      read_ptr  <= '0;
      send_ptr  <= '0;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      rx_word   <= '0;
      tx_shift  <= '0;
      attr_out  <= '0;
    end else begin
      mosi_sy <= {mosi_sy[0], mosi};
      sclk_sy <= {sclk_sy[0], sclk};
      cs_sy   <= {cs_sy[0], cs};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      rx_push <= 1'b0;
      if (cs_s)
        armed <= 1'b1;

      if (swap) begin
        ws_sel    <= ~ws_sel;
        rr_sel    <= ~rr_sel;
        send_cnt  <= write_cnt;
        read_cnt  <= recv_cnt;
        wr_ovf    <= 1'b0;
        spi_ovf   <= 1'b0;
        swap_pend <= 1'b0;
      end else if (signal_cycle) begin
        swap_pend <= 1'b1;
      end
      write_cnt <= wr_ok ? wr_cnt_e + CW'(1) : wr_cnt_e;
      recv_cnt  <= push_ok ? rcv_cnt_e + CW'(1) : rcv_cnt_e;
      read_ptr  <= rd_ok ? rd_ptr_e + CW'(1) : rd_ptr_e;
      if (signal_wr && !wr_ok)
        wr_ovf <= 1'b1;
      if (rx_push && !push_ok)
        spi_ovf <= 1'b1;

      rd_valid <= rd_ok;
      attr_out <= '0;
      if (signal_oe) begin
        attr_out[1] <= ovf_e;
        attr_out[0] <= ~rd_ok;
      end

      if (cs_s)
        frame_act <= 1'b0;
      if (cs_rise) begin
        bit_cnt  <= '0;
        send_ptr <= '0;
      end else if (cs_fall) begin
        frame_act <= 1'b1;
        bit_cnt   <= '0;
        if (CPHA == 0) begin
          tx_shift <= send_avail ? tx_next_word : '0;
          if (send_avail)
            send_ptr <= send_ptr + CW'(1);
        end else begin
          tx_shift <= '0;
        end
      end else if (frame_act) begin
        if (sample_edge) begin
          rx_shift <= {rx_shift[DATA_WIDTH-3:0], mosi_s};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            rx_word <= {rx_shift, mosi_s};
            rx_push <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        // A shift edge at bit 0 starts a new word; otherwise advance the current one.
        if (shift_edge) begin
          if (bit_cnt == '0) begin
            tx_shift <= send_avail ? tx_next_word : '0;
            if (send_avail)
              send_ptr <= send_ptr + CW'(1);
          end else begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pu_slave_spi_pbuf.sv
// Bench for pu_slave_spi_pbuf: four instances (one per CPOL/CPHA mode) receive identical
// traffic; a directed table, hand sequences and a queue-based random model check them.
module tb_pu_slave_spi_pbuf;
  localparam int DW   = 32;
  localparam int BS   = 10;
  localparam int HALF = 6;

  logic clk = 1'b0, rst = 1'b0;
  logic signal_cycle = 1'b0, signal_wr = 1'b0, signal_oe = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [3:0]    attr_in = '0;
  logic cs_v [4], sclk_v [4], mosi_v [4], miso_v [4];
  logic [DW-1:0] data_out_v [4];
  logic [3:0]    attr_out_v [4];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      pu_slave_spi_pbuf #(.DATA_WIDTH(DW), .ATTR_WIDTH(4), .BUF_SIZE(BS),
                          .CPOL(gi / 2), .CPHA(gi % 2)) dut (
        .clk(clk), .rst(rst), .signal_cycle(signal_cycle), .signal_wr(signal_wr),
        .data_in(data_in), .attr_in(attr_in), .signal_oe(signal_oe),
        .data_out(data_out_v[gi]), .attr_out(attr_out_v[gi]),
        .mosi(mosi_v[gi]), .sclk(sclk_v[gi]), .cs(cs_v[gi]), .miso(miso_v[gi]));
    end
  endgenerate

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input int k, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s mode%0d: got %h, expected %h", name, k, got, exp);
  endtask

  // Reference model: whole banks as queues, swaps as queue moves.
  logic [DW-1:0] m_wq[$], m_sq[$], m_rq[$], m_dq[$];
  bit m_wovf, m_sovf;

  task automatic m_reset();
    m_wq.delete(); m_sq.delete(); m_rq.delete(); m_dq.delete();
    m_wovf = 0; m_sovf = 0;
  endtask

  task automatic m_swap();
    m_sq = m_wq; m_wq.delete();
    m_dq = m_rq; m_rq.delete();
    m_wovf = 0; m_sovf = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_wr(input logic [DW-1:0] d);
    signal_wr = 1'b1; data_in = d;
    @(negedge clk);
    signal_wr = 1'b0;
  endtask

  task automatic do_cyc();
    signal_cycle = 1'b1;
    @(negedge clk);
    signal_cycle = 1'b0;
  endtask

  task automatic do_oe(input string name, input logic [DW-1:0] exp_d, input logic [3:0] exp_a);
    signal_oe = 1'b1;
    @(negedge clk);
    signal_oe = 1'b0;
    $display("oe %s: data=%h attr=%h (want %h/%h)", name, data_out_v[0], attr_out_v[0], exp_d, exp_a);
    for (int k = 0; k < 4; k++) begin
      check({name, "_data"}, k, data_out_v[k], exp_d);
      check({name, "_attr"}, k, DW'(attr_out_v[k]), DW'(exp_a));
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++)
      check({name, "_idle"}, k, data_out_v[k] | DW'(attr_out_v[k]), '0);
  endtask

  logic [DW-1:0] mtx [4];
  logic [DW-1:0] mrx [4][4];

  // Master frame driven to all four modes in lockstep; ends one clk after cs rises.
  task automatic spi_frame(input int nbits, input int cyc_edge);
    for (int k = 0; k < 4; k++) begin
      cs_v[k] = 1'b0;
      sclk_v[k] = (k / 2 != 0);
      mosi_v[k] = (k % 2 == 0) ? mtx[0][DW-1] : 1'b0;
      for (int j = 0; j < 4; j++) mrx[k][j] = '0;
    end
    repeat (HALF) @(negedge clk);
    for (int e = 0; e < 2 * nbits; e++) begin
      int b, w, i, nb;
      b = e / 2; w = b / DW; i = DW - 1 - (b % DW); nb = b + 1;
      if (e == cyc_edge) signal_cycle = 1'b1;
      for (int k = 0; k < 4; k++) begin
        if ((e % 2 == 0) == (k % 2 == 0)) mrx[k][w][i] = miso_v[k];
        if (k % 2 == 1 && e % 2 == 0) mosi_v[k] = mtx[w][i];
        if (k % 2 == 0 && e % 2 == 1 && nb < nbits) mosi_v[k] = mtx[nb / DW][DW - 1 - (nb % DW)];
        sclk_v[k] = ~sclk_v[k];
      end
      @(negedge clk);
      signal_cycle = 1'b0;
      repeat (HALF - 1) @(negedge clk);
    end
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 4; k++) cs_v[k] = 1'b1;
    @(negedge clk);
    $display("frame %0d bits: master rx %h %h", nbits, mrx[0][0], mrx[0][1]);
  endtask

  typedef enum int {OP_WR, OP_CYC, OP_OE, OP_FRM} op_e;
  typedef struct {
    op_e           op;
    logic [DW-1:0] a, b;
    logic [DW-1:0] ea, eb;
    logic [3:0]    eattr;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      cs_v[k] = 1'b1; sclk_v[k] = (k / 2 != 0); mosi_v[k] = 1'b0;
    end
    tbl.push_back('{OP_WR,  32'hA1A2A3A4, 0, 0, 0, 0});
    tbl.push_back('{OP_WR,  32'hB1B2B3B4, 0, 0, 0, 0});
    tbl.push_back('{OP_CYC, 0, 0, 0, 0, 0});
    tbl.push_back('{OP_FRM, 32'hC1C2C3C4, 32'hD1D2D3D4, 32'hA1A2A3A4, 32'hB1B2B3B4, 0});
    tbl.push_back('{OP_CYC, 0, 0, 0, 0, 0});
    tbl.push_back('{OP_OE,  0, 0, 32'hC1C2C3C4, 0, 4'h0});
    tbl.push_back('{OP_OE,  0, 0, 32'hD1D2D3D4, 0, 4'h0});
    tbl.push_back('{OP_OE,  0, 0, 32'h0, 0, 4'h1});
    for (int i = 1; i <= BS + 1; i++) tbl.push_back('{OP_WR, DW'(i), 0, 0, 0, 0});
    tbl.push_back('{OP_OE,  0, 0, 32'h0, 0, 4'h3});
    tbl.push_back('{OP_OE,  0, 0, 32'h0, 0, 4'h3});
    tbl.push_back('{OP_CYC, 0, 0, 0, 0, 0});
    tbl.push_back('{OP_OE,  0, 0, 32'h0, 0, 4'h1});
    tbl.push_back('{OP_FRM, 32'h0, 32'h0, 32'h00000001, 32'h00000002, 0});

    // Reset state, sampled while rst is held low
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check("rst_data", k, data_out_v[k], '0);
      check("rst_attr_miso", k, DW'({attr_out_v[k], miso_v[k]}), '0);
    end
    do_reset();

    foreach (tbl[t]) begin
      case (tbl[t].op)
        OP_WR:  do_wr(tbl[t].a);
        OP_CYC: do_cyc();
        OP_OE:  do_oe($sformatf("tbl%0d", t), tbl[t].ea, tbl[t].eattr);
        default: begin
          mtx[0] = tbl[t].a; mtx[1] = tbl[t].b;
          spi_frame(2 * DW, -1);
          repeat (4) @(negedge clk);
          for (int k = 0; k < 4; k++) begin
            check($sformatf("tbl%0d_rx0", t), k, mrx[k][0], tbl[t].ea);
            check($sformatf("tbl%0d_rx1", t), k, mrx[k][1], tbl[t].eb);
          end
        end
      endcase
    end

    // Cycle pulsed mid-frame: swap deferred until cs rises, then lands within 3 clk
    do_reset();
    do_wr(32'h5A5A0001);
    do_cyc();
    do_wr(32'h5A5A0002);
    repeat (4) @(negedge clk);
    mtx[0] = 32'h11110000; mtx[1] = 32'h22220000;
    spi_frame(2 * DW, 20);
    repeat (3) @(negedge clk);
    do_oe("defer_rd0", 32'h11110000, 4'h0);
    for (int k = 0; k < 4; k++) begin
      check("defer_tx0", k, mrx[k][0], 32'h5A5A0001);
      check("defer_tx1", k, mrx[k][1], 32'h0);
    end
    do_oe("defer_rd1", 32'h22220000, 4'h0);
    mtx[0] = 32'h0;
    spi_frame(DW, -1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) check("defer_newsend", k, mrx[k][0], 32'h5A5A0002);

    // cs raised after 12 bits: partial discarded, send pointer rewound
    do_reset();
    do_wr(32'hC0FFEE01);
    do_cyc();
    repeat (4) @(negedge clk);
    mtx[0] = 32'hABCDEF12;
    spi_frame(12, -1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) check("partial_tx", k, mrx[k][0], 32'hC0F00000);
    mtx[0] = 32'h13572468;
    spi_frame(DW, -1);
    repeat (4) @(negedge clk);
    for (int k = 0; k < 4; k++) check("rewind_tx", k, mrx[k][0], 32'hC0FFEE01);
    do_cyc();
    do_oe("partial_rd0", 32'h13572468, 4'h0);
    do_oe("partial_rd1", 32'h0, 4'h1);

    // Randomized traffic against the queue model
    do_reset();
    m_reset();
    for (int t = 0; t < 60; t++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        logic [DW-1:0] d;
        d = $urandom();
        do_wr(d);
        if (m_wq.size() < BS) m_wq.push_back(d); else m_wovf = 1;
      end else if (r <= 6) begin
        logic [DW-1:0] ed;
        logic [3:0] ea;
        ea = {2'b00, m_wovf | m_sovf, 1'b0};
        if (m_dq.size() > 0) ed = m_dq.pop_front();
        else begin ed = '0; ea[0] = 1'b1; end
        do_oe($sformatf("rnd%0d", t), ed, ea);
      end else if (r == 7) begin
        do_cyc();
        m_swap();
      end else begin
        int nw;
        nw = $urandom_range(1, 3);
        for (int j = 0; j < nw; j++) mtx[j] = $urandom();
        spi_frame(nw * DW, -1);
        repeat (3) @(negedge clk);
        for (int j = 0; j < nw; j++) begin
          logic [DW-1:0] ex;
          ex = (j < m_sq.size()) ? m_sq[j] : '0;
          for (int k = 0; k < 4; k++) check($sformatf("rnd%0d_rx%0d", t, j), k, mrx[k][j], ex);
          if (m_rq.size() < BS) m_rq.push_back(mtx[j]); else m_sovf = 1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pu_slave_spi_pbuf.md
PU_SLAVE_SPI_PBUF -- requirements
Module: pu_slave_spi_pbuf

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, NITTA data word width and SPI word length in bits.
REQ-002 SHALL provide parameter ATTR_WIDTH, default 4, attribute width (ATTR_WIDTH >= 2).
REQ-003 SHALL provide parameter BUF_SIZE, default 10, depth in words of every bank.
REQ-004 SHALL provide parameter CPOL, default 0, SPI clock idle level.
REQ-005 SHALL provide parameter CPHA, default 0, SPI phase: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-006 SHALL provide port clk, input, 1, system clock.
REQ-007 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-008 SHALL provide port signal_cycle, input, 1, computational cycle boundary pulse.
REQ-009 SHALL provide port signal_wr, input, 1, write strobe from NITTA bus.
REQ-010 SHALL provide port data_in, input, DATA_WIDTH, word to send.
REQ-011 SHALL provide port attr_in, input, ATTR_WIDTH, ignored.
REQ-012 SHALL provide port signal_oe, input, 1, read strobe.
REQ-013 SHALL provide port data_out, output, DATA_WIDTH, received word.
REQ-014 SHALL provide port attr_out, output, ATTR_WIDTH, [0] invalid, [1] overflow, others 0.
REQ-015 SHALL provide ports mosi/sclk/cs (input, 1) and miso (output, 1): SPI slave pins, cs active-low.

Function
REQ-016 SHALL synchronise mosi, sclk, cs through two clk flip-flops; sclk edges detected on synchronised value; sclk half-period >= 2 clk.
REQ-017 SHALL shift MSB first; sample mosi on sample edge per CPOL/CPHA; update miso on opposite edge; CPHA=0 drives first bit at cs fall.
REQ-018 SHALL hold four banks: write (NITTA fill), send (SPI drain), receive (SPI fill), read (NITTA drain); each with own count.
REQ-019 SHALL, on signal_wr with write count < BUF_SIZE, store data_in at write pointer, increment; at count = BUF_SIZE drop the word and set sticky write-overflow.
REQ-020 SHALL, on signal_oe, present next read-bank word on data_out one clk later, attr_out[0]=0; if read bank empty, data_out=0, attr_out[0]=1; pointer advances only on valid read.
REQ-021 SHALL drive data_out and attr_out to 0 in every cycle not following an oe cycle, except attr_out[1] = overflow flag during those response cycles.
REQ-022 SHALL, after DATA_WIDTH sampled bits, push the word into receive bank in the next clk; if full, drop it and set sticky SPI-overflow.
REQ-023 SHALL load send-bank words sequentially into the transmit shifter, one per SPI word; send bank exhausted -> miso 0 for remaining words.
REQ-024 SHALL, on cs rise, discard any partial word, clear bit counter, rewind send pointer to 0 (a frame retransmits the whole send bank).
REQ-025 SHALL, on signal_cycle with cs high, swap write<->send and receive<->read in the same clk; new write and receive banks emptied; read pointer 0.
REQ-026 SHALL, on signal_cycle with cs low, set swap-pending and execute the swap on the first clk cs is synchronised high; a second cycle while pending is merged.
REQ-027 SHALL clear both overflow flags at each executed swap; attr_out[1] = write-overflow OR SPI-overflow.
REQ-028 SHALL give signal_wr and signal_oe in a swap clk the post-swap banks.
REQ-029 SHALL keep miso 0 while cs high.

Reset
REQ-030 SHALL, while rst low, asynchronously force data_out=0, attr_out=0, miso=0, all counts, pointers, flags and swap-pending to 0, bank contents undefined.
REQ-031 SHALL, on rst low mid-frame, abandon the frame; frame resumes only after cs high then low.

Verification
REQ-032 Write A1A2A3A4, B1B2B3B4; cycle; master 2-word frame sending C1C2C3C4, D1D2D3D4 -> master receives A1A2A3A4, B1B2B3B4; after next cycle two oe -> data_out C1C2C3C4, D1D2D3D4, attr_out 0.
REQ-033 Third oe on emptied read bank -> data_out 0, attr_out[0]=1.
REQ-034 BUF_SIZE+1 writes 00000001..0000000B -> 0000000B dropped, attr_out[1]=1 on oe until next swap.
REQ-035 signal_cycle pulsed mid-frame -> no swap until cs rises; swap within 3 clk after synchronised cs high; frame data intact.
REQ-036 cs raised after 12 bits -> partial word discarded, receive count unchanged; next frame word received correctly.
REQ-037 Repeat REQ-032 for each CPOL/CPHA combination -> identical data.
